// File: rtl/pattern_detect_param_if.sv
`default_nettype none
// ============================================================================
//  Module      : pattern_detect_param_if
//  Description : Data, control and result signals of the programmable serial
//                pattern detector. The master side (bit source and control
//                block) drives the stream and pattern programming. The slave
//                side (detector) returns the match pulse, its registered copy
//                and the saturating match count.
//  Revision    : 1.0  initial release
// ============================================================================
interface pattern_detect_param_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
);
  logic             d_i;
  logic             valid_i;
  logic [PAT_W-1:0] pat_i;
  logic [PAT_W-1:0] mask_i;
  logic             pat_load_i;
  logic             overlap_i;
  logic             cnt_clr_i;
  logic             pattern;
  logic             pattern_q;
  logic [CNT_W-1:0] match_cnt_o;

  modport master (
    output d_i, valid_i, pat_i, mask_i, pat_load_i, overlap_i, cnt_clr_i,
    input  pattern, pattern_q, match_cnt_o
  );

  modport slave (
    input  d_i, valid_i, pat_i, mask_i, pat_load_i, overlap_i, cnt_clr_i,
    output pattern, pattern_q, match_cnt_o
  );
endinterface
`default_nettype wire

// File: rtl/pattern_detect_param.sv
`default_nettype none
// ============================================================================
//  Module      : pattern_detect_param
//  Description : Runtime-programmable serial pattern detector. Matches a
//                PAT_W-bit pattern with per-bit don't-care mask against a
//                valid-qualified bit stream, with overlapping or
//                non-overlapping detection, a zero-latency Mealy match pulse,
//                its registered copy and a saturating match counter.
//  Revision    : 1.0  initial release
// ============================================================================
module pattern_detect_param #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] DEF_PAT = 4'b1011,
  parameter int               CNT_W   = 8
) (
  input  wire logic              clk,
  input  wire logic              rst,
  pattern_detect_param_if.slave  bus
);

  // fill only has to reach PAT_W-1, so clog2(PAT_W) bits always suffice
  localparam int               FILL_W      = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] c_FILL_FULL = FILL_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0]  c_CNT_MAX   = '1;

  logic [PAT_W-1:0]  r_pat;
  logic [PAT_W-1:0]  r_mask;
  logic [PAT_W-2:0]  r_hist;
  logic [FILL_W-1:0] r_fill;
  logic              r_pattern_q;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_accept;
  logic              w_full;
  logic [PAT_W-1:0]  w_window;
  logic              w_match;
  logic [PAT_W-2:0]  w_hist_shift;
  logic [FILL_W-1:0] w_fill_inc;

  // A load cycle drops the data bit, so it never counts as an accepted bit
  assign w_accept     = bus.valid_i & ~bus.pat_load_i;
  assign w_full       = (r_fill == c_FILL_FULL);
  // Oldest bit lands in the MSB so the window lines up with the pattern MSB
  assign w_window     = {r_hist, bus.d_i};
  assign w_match      = w_accept & w_full & (((w_window ^ r_pat) & r_mask) == '0);
  // Slicing the window keeps the shift legal down to PAT_W = 2
  assign w_hist_shift = w_window[PAT_W-2:0];
  assign w_fill_inc   = w_full ? r_fill : (r_fill + 1'b1);

  assign bus.pattern     = w_match;
  assign bus.pattern_q   = r_pattern_q;
  assign bus.match_cnt_o = r_cnt;

  // Pattern programming plus bit history / fill tracking (fill is the sequence state)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pat  <= DEF_PAT;
      r_mask <= '1;
      r_hist <= '0;
      r_fill <= '0;
    end else if (bus.pat_load_i) begin
      r_pat  <= bus.pat_i;
      r_mask <= bus.mask_i;
      r_hist <= '0;
      r_fill <= '0;
    end else if (w_accept) begin
      if (w_match && !bus.overlap_i) begin
        r_hist <= '0;
        r_fill <= '0;
      end else begin
        r_hist <= w_hist_shift;
        r_fill <= w_fill_inc;
      end
    end
  end

  // Registered copy of the match pulse, one clock behind
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pattern_q <= 1'b0;
    end else begin
      r_pattern_q <= w_match;
    end
  end

  // Saturating match counter; a clear wins over a same-cycle match
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (bus.cnt_clr_i) begin
      r_cnt <= '0;
    end else if (w_match && (r_cnt != c_CNT_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pattern_detect_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pattern_detect_param
//  Description : Self-checking bench for pattern_detect_param. Two detectors
//                (8-bit and 3-bit counters) share one stimulus stream; a
//                queue-based bit-history model predicts every match.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pattern_detect_param;

  localparam int PAT_W = 4;

  logic clk;
  logic rst;

  logic             d, v, ld, ovl, clr;
  logic [PAT_W-1:0] pat, msk;

  int total = 0;
  int bad   = 0;

  // reference model state
  bit               mq[$];
  bit               sbq[$];
  logic [PAT_W-1:0] m_pat;
  logic [PAT_W-1:0] m_mask;
  int               m_cnt8;
  int               m_cnt3;
  logic             g_ovl;

  pattern_detect_param_if #(.PAT_W(PAT_W), .CNT_W(8)) bus8 ();
  pattern_detect_param_if #(.PAT_W(PAT_W), .CNT_W(3)) bus3 ();

  assign bus8.d_i        = d;
  assign bus8.valid_i    = v;
  assign bus8.pat_load_i = ld;
  assign bus8.overlap_i  = ovl;
  assign bus8.cnt_clr_i  = clr;
  assign bus8.pat_i      = pat;
  assign bus8.mask_i     = msk;
  assign bus3.d_i        = d;
  assign bus3.valid_i    = v;
  assign bus3.pat_load_i = ld;
  assign bus3.overlap_i  = ovl;
  assign bus3.cnt_clr_i  = clr;
  assign bus3.pat_i      = pat;
  assign bus3.mask_i     = msk;

  pattern_detect_param #(.PAT_W(PAT_W), .DEF_PAT(4'b1011), .CNT_W(8)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  pattern_detect_param #(.PAT_W(PAT_W), .DEF_PAT(4'b1011), .CNT_W(3)) u_dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit model_match(input bit dd, input bit acc);
    logic [PAT_W-1:0] w;
    int n;
    if (!acc) return 1'b0;
    n = mq.size();
    if (n < PAT_W - 1) return 1'b0;
    for (int i = 0; i < PAT_W - 1; i++) w[PAT_W-1-i] = mq[n-(PAT_W-1)+i];
    w[0] = dd;
    return (((w ^ m_pat) & m_mask) == '0);
  endfunction

  task automatic model_reset();
    mq.delete();
    sbq.delete();
    m_pat  = 4'b1011;
    m_mask = '1;
    m_cnt8 = 0;
    m_cnt3 = 0;
  endtask

  // One clock of stimulus: check the Mealy pulse, queue it, then check the
  // registered pulse and both counters after the edge.
  task automatic step(input bit dd, input bit vv, input bit ll, input bit oo,
                      input bit cc, input logic [PAT_W-1:0] pp, input logic [PAT_W-1:0] mm);
    bit e;
    bit eq;
    @(negedge clk);
    d = dd; v = vv; ld = ll; ovl = oo; clr = cc; pat = pp; msk = mm;
    e = model_match(dd, vv && !ll);
    #1;
    chk("pattern8", {31'b0, bus8.pattern}, {31'b0, e});
    chk("pattern3", {31'b0, bus3.pattern}, {31'b0, e});
    sbq.push_back(e);
    @(posedge clk);
    if (ll) begin
      m_pat  = pp;
      m_mask = mm;
      mq.delete();
    end else if (vv) begin
      if (e && !oo) begin
        mq.delete();
      end else begin
        mq.push_back(dd);
        if (mq.size() > PAT_W - 1) void'(mq.pop_front());
      end
    end
    if (cc) begin
      m_cnt8 = 0;
      m_cnt3 = 0;
    end else if (e) begin
      if (m_cnt8 < 255) m_cnt8++;
      if (m_cnt3 < 7)   m_cnt3++;
    end
    #1;
    eq = sbq.pop_front();
    chk("pattern_q", {31'b0, bus8.pattern_q}, {31'b0, eq});
    chk("cnt8", {24'b0, bus8.match_cnt_o}, m_cnt8);
    chk("cnt3", {29'b0, bus3.match_cnt_o}, m_cnt3);
  endtask

  task automatic feed(input bit dd);
    step(dd, 1'b1, 1'b0, g_ovl, 1'b0, '0, '0);
  endtask

  task automatic bubble(input bit dd);
    step(dd, 1'b0, 1'b0, g_ovl, 1'b0, '0, '0);
  endtask

  task automatic load(input logic [PAT_W-1:0] pp, input logic [PAT_W-1:0] mm);
    step(1'b1, 1'b1, 1'b1, g_ovl, 1'b0, pp, mm);
  endtask

  // Asynchronous reset away from any clock edge, with a live stream applied
  task automatic do_reset();
    @(negedge clk);
    #2;
    d = 1'b1; v = 1'b1; ld = 1'b0; clr = 1'b0;
    rst = 1'b0;
    #1;
    model_reset();
    chk("rst_pattern",   {31'b0, bus8.pattern},   0);
    chk("rst_pattern_q", {31'b0, bus8.pattern_q}, 0);
    chk("rst_cnt8",      {24'b0, bus8.match_cnt_o}, 0);
    chk("rst_cnt3",      {29'b0, bus3.match_cnt_o}, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_pattern", {31'b0, bus8.pattern}, 0);
    @(negedge clk);
    rst = 1'b1;
    v   = 1'b0;
  endtask

  initial begin
    rst = 1'b0; d = 1'b0; v = 1'b0; ld = 1'b0; ovl = 1'b1; clr = 1'b0;
    pat = '0; msk = '0; g_ovl = 1'b1;
    model_reset();

    // 1: default pattern 1011, overlapping
    do_reset();
    g_ovl = 1'b1;
    feed(1); feed(0); feed(1); feed(1); feed(0); feed(1); feed(1);
    chk("t1_cnt", {24'b0, bus8.match_cnt_o}, 2);

    // 2: same stream, non-overlapping
    do_reset();
    g_ovl = 1'b0;
    feed(1); feed(0); feed(1); feed(1); feed(0); feed(1); feed(1);
    chk("t2_cnt", {24'b0, bus8.match_cnt_o}, 1);

    // 3: bubbles between every bit are ignored
    do_reset();
    g_ovl = 1'b1;
    feed(1); bubble(0); feed(0); bubble(1); feed(1); bubble(0); feed(1); bubble(0);
    chk("t3_cnt", {24'b0, bus8.match_cnt_o}, 1);

    // 4: masked pattern, then load mid-stream discards history
    load(4'b1001, 4'b1011);
    feed(1); feed(1); feed(0); feed(1);
    feed(1); feed(0);
    load(4'b1001, 4'b1011);
    feed(0); feed(1);
    feed(1); feed(0); feed(0); feed(1);

    // 5: all-ones pattern, 3-bit counter saturates, clear beats a match
    do_reset();
    g_ovl = 1'b1;
    load(4'b1111, 4'b1111);
    for (int i = 0; i < 12; i++) feed(1);
    chk("t5_cnt8", {24'b0, bus8.match_cnt_o}, 9);
    chk("t5_cnt3", {29'b0, bus3.match_cnt_o}, 7);
    step(1, 1, 0, 1, 1, '0, '0);
    chk("t5_clr", {29'b0, bus3.match_cnt_o}, 0);

    // 6: async reset right after a match and after 3 matching bits
    do_reset();
    feed(1); feed(0); feed(1); feed(1);
    do_reset();
    feed(1); feed(0); feed(1);
    do_reset();
    feed(1); feed(0); feed(1); feed(1);
    chk("t6_cnt", {24'b0, bus8.match_cnt_o}, 1);

    // mask of zero: every accept with full history matches
    load(4'b0000, 4'b0000);
    feed(0); feed(1); feed(0); feed(1); feed(1);

    // random stream with random overlap, loads and clears
    do_reset();
    for (int i = 0; i < 540; i++) begin
      if ($urandom_range(15) == 0) g_ovl = ~g_ovl;
      if ($urandom_range(63) == 0) begin
        if ($urandom_range(3) == 0)
          load(PAT_W'($urandom_range(15)), 4'b0000);
        else
          load(PAT_W'($urandom_range(15)), PAT_W'($urandom_range(15)));
      end else begin
        step($urandom_range(1) == 1, $urandom_range(3) != 0, 1'b0, g_ovl,
             $urandom_range(127) == 0, '0, '0);
      end
    end
    chk("rand_cnt8", {24'b0, bus8.match_cnt_o}, m_cnt8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
